// File: rtl/act_func_pipe.sv
// act_func_pipe: selectable activation (identity/ReLU/clamp/step) on a
// signed fixed-point sample, buffered with its destination tag in a FIFO.
// Ports: clk, rst (sync, active-high); in_valid/in_ready/in_val/in_sel/
// in_dest push side; out_valid/out_ready/out_val/out_dest pop side;
// fifo_count occupancy. Macro ACTFN_LEAKY_EN makes sel 01 leaky ReLU.
module act_func_pipe #(
  parameter int DATA_W     = 16,
  parameter int FRAC_BITS  = 8,
  parameter int DEST_W     = 16,
  parameter int DEPTH      = 4,
  parameter int LEAK_SHIFT = 3,
  localparam int CW        = $clog2(DEPTH + 1),
  localparam int PW        = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_val,
  input  logic [1:0]        in_sel,
  input  logic [DEST_W-1:0] in_dest,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_val,
  output logic [DEST_W-1:0] out_dest,
  output logic [CW-1:0]     fifo_count
);

  localparam logic [DATA_W-1:0] ONE =
    {{(DATA_W-1){1'b0}}, 1'b1} << FRAC_BITS;

  logic [DATA_W-1:0] r_val  [DEPTH];
  logic [DEST_W-1:0] r_dest [DEPTH];
  logic [PW-1:0]     r_wptr;
  logic [PW-1:0]     r_rptr;
  logic [CW-1:0]     r_count;

  logic              w_neg;
  logic              w_gt_one;
  logic [DATA_W-1:0] w_act;
  logic              w_push;
  logic              w_pop;

  assign w_neg    = in_val[DATA_W-1];
  assign w_gt_one = $signed(in_val) > $signed(ONE);

  always_comb begin
    w_act = in_val;
    unique case (in_sel)
      2'b00: w_act = in_val;
`ifdef ACTFN_LEAKY_EN
      2'b01: w_act = w_neg ? ($signed(in_val) >>> LEAK_SHIFT) : in_val;
`else
      2'b01: w_act = w_neg ? '0 : in_val;
`endif
      2'b10: w_act = w_neg ? '0 : (w_gt_one ? ONE : in_val);
      2'b11: w_act = w_neg ? '0 : ONE;
    endcase
  end

  // No same-cycle credit: a full FIFO refuses input even while popping.
  assign in_ready   = !rst && (r_count != CW'(DEPTH));
  assign out_valid  = (r_count != '0);
  assign w_push     = in_valid && in_ready;
  assign w_pop      = out_valid && out_ready;
  assign out_val    = r_val[r_rptr];
  assign out_dest   = r_dest[r_rptr];
  assign fifo_count = r_count;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        r_val[i]  <= '0;
        r_dest[i] <= '0;
      end
    end else begin
      if (w_push) begin
        r_val[r_wptr]  <= w_act;
        r_dest[r_wptr] <= in_dest;
        r_wptr         <= r_wptr + PW'(1);
      end
      if (w_pop) begin
        r_rptr <= r_rptr + PW'(1);
      end
      unique case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: tb/tb_act_func_pipe.sv
// Testbench for act_func_pipe: directed scenarios plus randomized traffic
// compared against a queue-based reference model.
module tb_act_func_pipe;

  localparam int DEPTH = 4;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_val;
  logic [1:0]  in_sel;
  logic [15:0] in_dest;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_val;
  logic [15:0] out_dest;
  logic [2:0]  fifo_count;

  int checks   = 0;
  int failures = 0;

  logic [31:0] mq[$];

  act_func_pipe dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_val     (in_val),
    .in_sel     (in_sel),
    .in_dest    (in_dest),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_val    (out_val),
    .out_dest   (out_dest),
    .fifo_count (fifo_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [15:0] ref_act(logic [15:0] v, logic [1:0] s);
    int x;
    int r;
    x = int'($signed(v));
    case (s)
      2'd0: r = x;
`ifdef ACTFN_LEAKY_EN
      2'd1: r = (x < 0) ? -((-x + 7) / 8) : x;
`else
      2'd1: r = (x < 0) ? 0 : x;
`endif
      2'd2: r = (x < 0) ? 0 : ((x > 256) ? 256 : x);
      default: r = (x >= 0) ? 256 : 0;
    endcase
    return r[15:0];
  endfunction

  task automatic tick();
    bit push;
    bit pop;
    push = in_valid && !rst && (mq.size() != DEPTH);
    pop  = out_ready && !rst && (mq.size() != 0);
    @(posedge clk);
    if (rst) begin
      mq.delete();
    end else begin
      if (pop) void'(mq.pop_front());
      if (push) mq.push_back({in_dest, ref_act(in_val, in_sel)});
    end
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    checks++;
    if (out_valid !== 1'b0 || fifo_count !== 3'd0) begin
      failures++;
      $display("FAIL reset_flags valid=%b count=%0d want 0/0",
               out_valid, fifo_count);
    end
    checks++;
    if (out_val !== 16'h0 || out_dest !== 16'h0) begin
      failures++;
      $display("FAIL reset_head val=%h dest=%h want 0/0", out_val, out_dest);
    end
    checks++;
    if (in_ready !== 1'b0) begin
      failures++;
      $display("FAIL reset_in_ready got=%b want 0", in_ready);
    end
    rst = 1'b0;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin
      failures++;
      $display("FAIL post_reset_in_ready got=%b want 1", in_ready);
    end
  endtask

  task automatic test_identity();
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_val    = 16'h8123;
    in_sel    = 2'b00;
    in_dest   = 16'h0042;
    tick();
    in_valid = 1'b0;
    checks++;
    if (out_valid !== 1'b1 || out_val !== 16'h8123 || out_dest !== 16'h0042) begin
      failures++;
      $display("FAIL identity v=%b val=%h dest=%h want 1/8123/0042",
               out_valid, out_val, out_dest);
    end
    tick();
    checks++;
    if (fifo_count !== 3'd0 || out_valid !== 1'b0) begin
      failures++;
      $display("FAIL identity_pop count=%0d v=%b want 0/0",
               fifo_count, out_valid);
    end
  endtask

  task automatic test_relu();
    logic [15:0] v[4];
    logic [15:0] e[4];
    v = '{16'hFF00, 16'h0280, 16'hFFFF, 16'h0000};
`ifdef ACTFN_LEAKY_EN
    e = '{16'hFFE0, 16'h0280, 16'hFFFF, 16'h0000};
`else
    e = '{16'h0000, 16'h0280, 16'h0000, 16'h0000};
`endif
    out_ready = 1'b1;
    in_sel    = 2'b01;
    in_valid  = 1'b1;
    for (int i = 0; i < 4; i++) begin
      in_val  = v[i];
      in_dest = 16'(i + 16'h10);
      tick();
      checks++;
      if (out_valid !== 1'b1 || out_val !== e[i] || out_dest !== 16'(i + 16'h10)) begin
        failures++;
        $display("FAIL relu_%0d v=%b val=%h dest=%h want 1/%h/%h",
                 i, out_valid, out_val, out_dest, e[i], 16'(i + 16'h10));
      end
    end
    in_valid = 1'b0;
    tick();
  endtask

  task automatic test_clamp_step();
    logic [1:0]  s[8];
    logic [15:0] v[8];
    logic [15:0] e[8];
    s = '{2'b10, 2'b10, 2'b10, 2'b10, 2'b10, 2'b11, 2'b11, 2'b11};
    v = '{16'h0300, 16'hFFFF, 16'h0080, 16'h0100, 16'h0101,
          16'h0000, 16'h8000, 16'h7FFF};
    e = '{16'h0100, 16'h0000, 16'h0080, 16'h0100, 16'h0100,
          16'h0100, 16'h0000, 16'h0100};
    out_ready = 1'b1;
    in_valid  = 1'b1;
    for (int i = 0; i < 8; i++) begin
      in_sel  = s[i];
      in_val  = v[i];
      in_dest = 16'(i);
      tick();
      checks++;
      if (out_valid !== 1'b1 || out_val !== e[i] || out_dest !== 16'(i)) begin
        failures++;
        $display("FAIL clamp_step_%0d sel=%0d in=%h got=%h want=%h v=%b",
                 i, s[i], v[i], out_val, e[i], out_valid);
      end
    end
    in_valid = 1'b0;
    tick();
  endtask

  task automatic test_backpressure();
    logic [15:0] got[$];
    out_ready = 1'b0;
    in_valid  = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      in_dest = 16'(i);
      in_val  = 16'($urandom);
      in_sel  = 2'($urandom);
      tick();
    end
    in_dest = 16'd5;
    in_val  = 16'($urandom);
    checks++;
    if (fifo_count !== 3'd4 || in_ready !== 1'b0) begin
      failures++;
      $display("FAIL bp_full count=%0d rdy=%b want 4/0", fifo_count, in_ready);
    end
    tick();
    checks++;
    if (fifo_count !== 3'd4) begin
      failures++;
      $display("FAIL bp_hold count=%0d want 4", fifo_count);
    end
    out_ready = 1'b1;
    for (int c = 0; c < 20 && got.size() < 5; c++) begin
      bit acc;
      acc = in_valid && in_ready;
      if (out_valid) got.push_back(out_dest);
      tick();
      if (acc) in_valid = 1'b0;
    end
    checks++;
    if (got.size() != 5) begin
      failures++;
      $display("FAIL bp_timeout popped=%0d want 5", got.size());
    end
    for (int k = 0; k < got.size(); k++) begin
      checks++;
      if (got[k] !== 16'(k + 1)) begin
        failures++;
        $display("FAIL bp_order_%0d got=%0d want=%0d", k, got[k], k + 1);
      end
    end
    in_valid = 1'b0;
    tick();
  endtask

  task automatic test_full_pop();
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_sel    = 2'b00;
    for (int i = 0; i < 4; i++) begin
      in_val  = 16'($urandom);
      in_dest = 16'(16'h100 + i);
      tick();
    end
    in_dest   = 16'h0200;
    out_ready = 1'b1;
    tick();
    checks++;
    if (fifo_count !== 3'd3 || fifo_count !== 3'(mq.size())) begin
      failures++;
      $display("FAIL full_pop count=%0d want 3", fifo_count);
    end
    tick();
    checks++;
    if (fifo_count !== 3'd3) begin
      failures++;
      $display("FAIL full_pushpop count=%0d want 3", fifo_count);
    end
    checks++;
    if (out_dest !== 16'h0102 || out_val !== mq[0][15:0]) begin
      failures++;
      $display("FAIL full_pushpop_head dest=%h val=%h want 0102/%h",
               out_dest, out_val, mq[0][15:0]);
    end
    in_valid = 1'b0;
    repeat (5) tick();
  endtask

  task automatic test_reset_mid();
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_sel    = 2'b00;
    for (int i = 0; i < 3; i++) begin
      in_val  = 16'h1111 * 16'(i + 1);
      in_dest = 16'(i + 7);
      tick();
    end
    in_valid = 1'b0;
    checks++;
    if (fifo_count !== 3'd3) begin
      failures++;
      $display("FAIL rmid_pre count=%0d want 3", fifo_count);
    end
    rst = 1'b1;
    out_ready = 1'b1;
    tick();
    rst = 1'b0;
    checks++;
    if (out_valid !== 1'b0 || fifo_count !== 3'd0 || out_val !== 16'h0) begin
      failures++;
      $display("FAIL rmid_clear v=%b count=%0d val=%h want 0/0/0000",
               out_valid, fifo_count, out_val);
    end
    in_valid = 1'b1;
    in_val   = 16'h0ABC;
    in_sel   = 2'b11;
    in_dest  = 16'h0033;
    tick();
    in_valid = 1'b0;
    checks++;
    if (out_valid !== 1'b1 || out_val !== 16'h0100 || out_dest !== 16'h0033) begin
      failures++;
      $display("FAIL rmid_after v=%b val=%h dest=%h want 1/0100/0033",
               out_valid, out_val, out_dest);
    end
    tick();
  endtask

  task automatic test_random();
    int bad;
    bad = 0;
    for (int c = 0; c < 400; c++) begin
      rst       = ($urandom_range(0, 79) == 0);
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 2) != 0);
      in_val    = 16'($urandom);
      in_sel    = 2'($urandom);
      in_dest   = 16'($urandom);
      #1;
      checks++;
      if (in_ready !== (!rst && mq.size() != DEPTH)) begin
        failures++;
        if (bad++ < 10)
          $display("FAIL rnd_in_ready cyc=%0d got=%b size=%0d", c, in_ready, mq.size());
      end
      tick();
      checks++;
      if (out_valid !== (mq.size() != 0) || fifo_count !== 3'(mq.size())) begin
        failures++;
        if (bad++ < 10)
          $display("FAIL rnd_flags cyc=%0d v=%b count=%0d want size=%0d",
                   c, out_valid, fifo_count, mq.size());
      end
      if (mq.size() != 0) begin
        checks++;
        if (out_val !== mq[0][15:0] || out_dest !== mq[0][31:16]) begin
          failures++;
          if (bad++ < 10)
            $display("FAIL rnd_head cyc=%0d val=%h dest=%h want %h/%h",
                     c, out_val, out_dest, mq[0][15:0], mq[0][31:16]);
        end
      end
    end
    rst      = 1'b0;
    in_valid = 1'b0;
    tick();
  endtask

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_val    = '0;
    in_sel    = '0;
    in_dest   = '0;
    out_ready = 1'b0;
    test_reset();
    test_identity();
    test_relu();
    test_clamp_step();
    test_backpressure();
    test_full_pop();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
